// File: rtl/pipe_ctrl_bubble_if.sv
// pipe_ctrl_bubble_if: decode-to-execute control handshake bundle
interface pipe_ctrl_bubble_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_valid;
    logic              hazard;
    logic              flush;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_valid;
    logic              stall;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_ctrl, id_valid, hazard, flush,
        input  ex_ctrl, ex_valid, stall, bubble_cnt
    );

    modport slave (
        input  id_ctrl, id_valid, hazard, flush,
        output ex_ctrl, ex_valid, stall, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl_bubble.sv
// pipe_ctrl_bubble: ID/EX control register with load-use bubble insertion and flush
module pipe_ctrl_bubble #(
    parameter int CTRL_W        = 8,
    parameter int BUBBLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input logic                clk,
    input logic                rst_n,
    pipe_ctrl_bubble_if.slave  bus
);
    typedef enum logic {RUN, STALL} state_t;

    state_t     state, nxt;
    logic [3:0] rem, rem_nxt;
    logic       bubble, kill;

    always_comb begin
        nxt     = state;
        rem_nxt = rem;
        bubble  = 1'b0;
        if (state == RUN) begin
            if (!bus.flush && bus.hazard && bus.id_valid) begin
                bubble = 1'b1;
                if (BUBBLE_CYCLES > 1) begin
                    nxt     = STALL;
                    rem_nxt = 4'(BUBBLE_CYCLES - 1);
                end
            end
        end else if (bus.flush) begin
            nxt     = RUN;
            rem_nxt = 4'd0;
        end else begin
            bubble  = 1'b1;
            rem_nxt = rem - 4'd1;
            nxt     = (rem == 4'd1) ? RUN : STALL;
        end
        kill = bus.flush || bubble;
    end

    // every bubble cycle is also a stall cycle; reset masks the request
    assign bus.stall = rst_n && bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            rem            <= 4'd0;
            bus.ex_ctrl    <= {CTRL_W{1'b0}};
            bus.ex_valid   <= 1'b0;
            bus.bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            state        <= nxt;
            rem          <= rem_nxt;
            bus.ex_ctrl  <= kill ? {CTRL_W{1'b0}} : bus.id_ctrl;
            bus.ex_valid <= kill ? 1'b0 : bus.id_valid;
            if (bubble && bus.bubble_cnt != {CNT_W{1'b1}})
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_bubble.sv
// tb_pipe_ctrl_bubble: directed checks for bubble insertion, flush and counter saturation
module tb_pipe_ctrl_bubble;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_bubble_if #(.CTRL_W(8), .CNT_W(16)) b1 ();
    pipe_ctrl_bubble_if #(.CTRL_W(8), .CNT_W(16)) b3 ();
    pipe_ctrl_bubble_if #(.CTRL_W(8), .CNT_W(2))  bs ();

    pipe_ctrl_bubble #(.CTRL_W(8), .BUBBLE_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pipe_ctrl_bubble #(.CTRL_W(8), .BUBBLE_CYCLES(3), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    pipe_ctrl_bubble #(.CTRL_W(8), .BUBBLE_CYCLES(1), .CNT_W(2))  us (.clk(clk), .rst_n(rst_n), .bus(bs));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
        {b1.id_ctrl, b1.id_valid, b1.hazard, b1.flush} = {8'hFF, 1'b1, 1'b1, 1'b0};
        {b3.id_ctrl, b3.id_valid, b3.hazard, b3.flush} = {8'hFF, 1'b1, 1'b0, 1'b0};
        {bs.id_ctrl, bs.id_valid, bs.hazard, bs.flush} = {8'h00, 1'b0, 1'b0, 1'b0};
        tick();
        tick();
        check("rst_ctrl", 32'(b1.ex_ctrl), 32'h0);
        check("rst_valid", 32'(b1.ex_valid), 32'h0);
        check("rst_stall", 32'(b1.stall), 32'h0);
        check("rst_cnt", 32'(b1.bubble_cnt), 32'h0);
        rst_n = 1'b1;
        b1.hazard = 1'b0;
        tick();
        check("rel_ctrl", 32'(b1.ex_ctrl), 32'hFF);
        check("rel_valid", 32'(b1.ex_valid), 32'h1);

        for (int i = 0; i < 3; i++) begin
            b1.id_ctrl = seq[i];
            #1 check("pt_stall", 32'(b1.stall), 32'h0);
            tick();
            check("pt_ctrl", 32'(b1.ex_ctrl), 32'(seq[i]));
        end

        b1.id_ctrl = 8'hA5;
        b1.hazard = 1'b1;
        #1 check("h1_stall", 32'(b1.stall), 32'h1);
        tick();
        check("h1_bub_ctrl", 32'(b1.ex_ctrl), 32'h0);
        check("h1_bub_valid", 32'(b1.ex_valid), 32'h0);
        check("h1_cnt", 32'(b1.bubble_cnt), 32'h1);
        b1.hazard = 1'b0;
        #1 check("h1_stall_end", 32'(b1.stall), 32'h0);
        tick();
        check("h1_ctrl", 32'(b1.ex_ctrl), 32'hA5);
        check("h1_valid", 32'(b1.ex_valid), 32'h1);

        b3.id_ctrl = 8'h3C;
        b3.hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("h3_stall", 32'(b3.stall), 32'h1);
            tick();
            check("h3_bub", 32'(b3.ex_ctrl), 32'h0);
            b3.hazard = 1'b0;
        end
        #1 check("h3_stall_end", 32'(b3.stall), 32'h0);
        tick();
        check("h3_ctrl", 32'(b3.ex_ctrl), 32'h3C);
        check("h3_cnt", 32'(b3.bubble_cnt), 32'h3);

        b3.id_ctrl = 8'h5A;
        b3.hazard = 1'b1;
        tick();
        b3.hazard = 1'b0;
        b3.flush = 1'b1;
        #1 check("fl_stall", 32'(b3.stall), 32'h0);
        tick();
        check("fl_ctrl", 32'(b3.ex_ctrl), 32'h0);
        check("fl_valid", 32'(b3.ex_valid), 32'h0);
        check("fl_cnt", 32'(b3.bubble_cnt), 32'h4);
        b3.flush = 1'b0;
        #1 check("fl_run", 32'(b3.stall), 32'h0);
        tick();
        check("fl_resume", 32'(b3.ex_ctrl), 32'h5A);
        b3.id_ctrl = 8'h77;
        b3.hazard = 1'b1;
        b3.flush = 1'b1;
        #1 check("fh_stall", 32'(b3.stall), 32'h0);
        tick();
        check("fh_ctrl", 32'(b3.ex_ctrl), 32'h0);
        check("fh_cnt", 32'(b3.bubble_cnt), 32'h4);
        {b3.hazard, b3.flush} = 2'b00;

        bs.id_ctrl = 8'h01;
        bs.id_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bs.hazard = 1'b1;
            tick();
            check("sat_cnt", 32'(bs.bubble_cnt), 32'(sat_exp[i]));
            bs.hazard = 1'b0;
            tick();
        end

        b3.id_ctrl = 8'h42;
        b3.hazard = 1'b1;
        tick();
        b3.hazard = 1'b0;
        #1 check("rs_in_stall", 32'(b3.stall), 32'h1);
        rst_n = 1'b0;
        #1 check("rs_stall_rst", 32'(b3.stall), 32'h0);
        tick();
        rst_n = 1'b1;
        #1 check("rs_run", 32'(b3.stall), 32'h0);
        tick();
        check("rs_ctrl", 32'(b3.ex_ctrl), 32'h42);
        check("rs_cnt", 32'(b3.bubble_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
